// File: rtl/game_input_pkg.sv
// Shared types and constants for the game input arbiter.
// Command ids map to the button requesters in order.
package game_input_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    COOL  = 2'd2
  } arb_state_t;

  localparam int N_REQ_DEF = 4;

  localparam int CMD_FLAP    = 0;
  localparam int CMD_START   = 1;
  localparam int CMD_PAUSE   = 2;
  localparam int CMD_RESTART = 3;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set pending bit at or after ptr,
// wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  idx,
  output logic             found
);

  logic [ID_W:0] s;

  // Scan farthest-first so the candidate nearest ptr wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    s     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      s = {1'b0, ptr} + (ID_W + 1)'(k);
      if (s >= (ID_W + 1)'(N_REQ))
        s = s - (ID_W + 1)'(N_REQ);
      if (pending[s[ID_W-1:0]]) begin
        idx   = s[ID_W-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/input_arbiter.sv
// Arbitrates debounced button pulses into one command
// at a time, with a cooldown and a duplicate-drop counter.
module input_arbiter
  import game_input_pkg::*;
#(
  parameter  int N_REQ    = N_REQ_DEF,
  parameter  int COOLDOWN = 16,
  parameter  int CNT_W    = 8,
  localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req_pulse,
  input  logic             enable,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [ID_W-1:0]  cmd_id,
  output logic [CNT_W-1:0] drop_count,
  output logic             busy
);

  localparam int CW =
    (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [CW-1:0] COOL_LOAD =
    (COOLDOWN == 0) ? '0 : CW'(COOLDOWN - 1);
  localparam logic [31:0] DMAX =
    (32'd1 << CNT_W) - 32'd1;

  arb_state_t       state, state_n;
  logic [N_REQ-1:0] pending, pending_n;
  logic [ID_W-1:0]  rr_ptr, rr_ptr_n;
  logic [ID_W-1:0]  cmd_id_n;
  logic [CW-1:0]    cool_cnt, cool_n;
  logic [CNT_W-1:0] drop_n;

  logic [N_REQ-1:0] id_oh, keep_oh, clr_oh, drops;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_found;
  logic             hs;
  logic [31:0]      dsum;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .pending (pending),
    .ptr     (rr_ptr),
    .idx     (pick_idx),
    .found   (pick_found)
  );

  assign cmd_valid = (state == OFFER);
  assign busy      = (state != IDLE);

  always_comb begin
    hs      = (state == OFFER) && cmd_ready;
    id_oh   = N_REQ'(1) << cmd_id;
    keep_oh = (state == OFFER) ? id_oh : '0;
    // A pulse coinciding with its own handshake re-arms the bit.
    clr_oh  = (hs && !(enable && req_pulse[cmd_id]))
            ? id_oh : '0;
    if (enable) begin
      drops     = req_pulse & pending & ~(hs ? id_oh : '0);
      pending_n = (pending | req_pulse) & ~clr_oh;
    end else begin
      drops     = '0;
      pending_n = pending & keep_oh & ~clr_oh;
    end
    dsum   = 32'(drop_count) + 32'($countones(drops));
    drop_n = (dsum > DMAX) ? '1 : dsum[CNT_W-1:0];
  end

  always_comb begin
    state_n  = state;
    cmd_id_n = cmd_id;
    rr_ptr_n = rr_ptr;
    cool_n   = cool_cnt;
    unique case (state)
      IDLE: begin
        if (enable && pick_found) begin
          state_n  = OFFER;
          cmd_id_n = pick_idx;
        end
      end
      OFFER: begin
        if (cmd_ready) begin
          rr_ptr_n = (cmd_id == ID_W'(N_REQ - 1))
                   ? '0 : cmd_id + 1'b1;
          if (COOLDOWN == 0) begin
            state_n = IDLE;
          end else begin
            state_n = COOL;
            cool_n  = COOL_LOAD;
          end
        end
      end
      COOL: begin
        if (cool_cnt == '0) state_n = IDLE;
        else cool_n = cool_cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= '0;
      rr_ptr     <= '0;
      cool_cnt   <= '0;
      drop_count <= '0;
      cmd_id     <= '0;
    end else begin
      state      <= state_n;
      pending    <= pending_n;
      rr_ptr     <= rr_ptr_n;
      cool_cnt   <= cool_n;
      drop_count <= drop_n;
      cmd_id     <= cmd_id_n;
    end
  end

endmodule

// File: tb/tb_input_arbiter.sv
// Scoreboard bench for input_arbiter: reference model,
// directed scenarios and a randomized soak.
module tb_input_arbiter;

  localparam int N    = 4;
  localparam int CD   = 16;
  localparam int DMAX = 255;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req_pulse = '0;
  logic       enable = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [1:0] cmd_id;
  logic [7:0] drop_count;
  logic       busy;

  logic       s_reset = 1'b1;
  logic [3:0] s_pulse = '0;
  logic       s_en = 1'b0;
  logic       s_ready = 1'b0;
  logic       s_valid;
  logic [1:0] s_id;
  logic [1:0] s_drop;
  logic       s_busy;

  always #5 clk = ~clk;

  input_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req_pulse  (req_pulse),
    .enable     (enable),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_id     (cmd_id),
    .drop_count (drop_count),
    .busy       (busy)
  );

  input_arbiter #(
    .N_REQ    (4),
    .COOLDOWN (0),
    .CNT_W    (2)
  ) dut_sat (
    .clk        (clk),
    .reset      (s_reset),
    .req_pulse  (s_pulse),
    .enable     (s_en),
    .cmd_valid  (s_valid),
    .cmd_ready  (s_ready),
    .cmd_id     (s_id),
    .drop_count (s_drop),
    .busy       (s_busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  int exp_q[$];
  int obs_id[$];
  int obs_cyc[$];

  // Reference model state
  bit [3:0] m_pend;
  bit       m_offer;
  int       m_id, m_ptr, m_cool, m_drops;
  bit       m_hs, m_any, m_old_offer, m_found;
  int       m_old_id, m_j;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_pend  = '0;
      m_offer = 1'b0;
      m_id    = 0;
      m_ptr   = 0;
      m_cool  = 0;
      m_drops = 0;
      exp_q.delete();
    end else begin
      m_hs        = m_offer && cmd_ready;
      m_any       = |m_pend;
      m_old_offer = m_offer;
      m_old_id    = m_id;
      if (enable)
        for (int i = 0; i < N; i++)
          if (req_pulse[i] && m_pend[i] &&
              !(m_hs && i == m_old_id))
            m_drops = (m_drops >= DMAX) ? DMAX : m_drops + 1;
      if (m_offer) begin
        if (m_hs) begin
          m_offer = 1'b0;
          m_ptr   = (m_id + 1) % N;
          m_cool  = CD;
        end
      end else if (m_cool > 0) begin
        m_cool--;
      end else if (enable && m_any) begin
        m_found = 1'b0;
        for (int k = 0; k < N; k++) begin
          m_j = (m_ptr + k) % N;
          if (!m_found && m_pend[m_j]) begin
            m_found = 1'b1;
            m_id    = m_j;
          end
        end
        m_offer = 1'b1;
        exp_q.push_back(m_id);
      end
      for (int i = 0; i < N; i++) begin
        if (!enable) begin
          if (!(m_old_offer && i == m_old_id)) m_pend[i] = 1'b0;
        end else if (req_pulse[i]) begin
          m_pend[i] = 1'b1;
        end
      end
      if (m_hs && !(enable && req_pulse[m_old_id]))
        m_pend[m_old_id] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      chk("valid", cmd_valid, m_offer);
      chk("busy", busy, m_offer || m_cool > 0);
      chk("drops", drop_count, m_drops);
      if (m_offer) chk("id", cmd_id, m_id);
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          chk("hs_expected", 0, 1);
        end else begin
          chk("hs_id", cmd_id, exp_q.pop_front());
        end
        obs_id.push_back(cmd_id);
        obs_cyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_pulse = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while ((busy || cmd_valid) && n < maxc) begin
      step();
      n++;
    end
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  task automatic wait_grants(input int cnt);
    int n;
    n = 0;
    while (obs_id.size() < cnt && n < 200) begin
      step();
      n++;
    end
    chk("grant_count", obs_id.size(), cnt);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit seen;
    int exp2[4];
    exp2 = '{2, 3, 0, 1};

    // Reset state
    reset = 1'b1;
    s_reset = 1'b1;
    step();
    step();
    chk("rst_valid", cmd_valid, 0);
    chk("rst_id", cmd_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_count, 0);
    reset = 1'b0;
    s_reset = 1'b0;
    mon_en = 1'b1;

    // Single flap latency and cooldown length
    enable = 1'b1;
    cmd_ready = 1'b1;
    req_pulse = 4'b0001;
    step();
    req_pulse = '0;
    chk("lat_t1_valid", cmd_valid, 0);
    step();
    chk("lat_t2_valid", cmd_valid, 1);
    chk("lat_t2_id", cmd_id, 0);
    step();
    n = 0;
    while (busy && n < 40) begin
      n++;
      step();
    end
    chk("cool_len", n, 16);

    // Contention: two rounds
    do_reset();
    obs_id.delete();
    obs_cyc.delete();
    req_pulse = 4'b1111;
    step();
    req_pulse = '0;
    wait_grants(4);
    if (obs_id.size() == 4)
      for (int k = 0; k < 4; k++) begin
        chk("rr1_id", obs_id[k], k);
        if (k > 0) chk("rr1_gap", obs_cyc[k] - obs_cyc[k-1], 18);
      end
    wait_idle(40);
    obs_id.delete();
    req_pulse = 4'b0010;
    step();
    req_pulse = '0;
    wait_grants(1);
    if (obs_id.size() == 1) chk("rr_mid_id", obs_id[0], 1);
    wait_idle(40);
    obs_id.delete();
    req_pulse = 4'b1111;
    step();
    req_pulse = '0;
    wait_grants(4);
    if (obs_id.size() == 4)
      for (int k = 0; k < 4; k++) chk("rr2_id", obs_id[k], exp2[k]);
    wait_idle(40);

    // Backpressure, duplicate drop, pulse at handshake
    do_reset();
    cmd_ready = 1'b0;
    req_pulse = 4'b0100;
    step();
    req_pulse = '0;
    step();
    for (int i = 0; i < 10; i++) begin
      if (i == 4) req_pulse = 4'b0100;
      step();
      req_pulse = '0;
      chk("bp_hold", {cmd_valid, cmd_id}, {1'b1, 2'd2});
    end
    chk("bp_drop", drop_count, 1);
    cmd_ready = 1'b1;
    req_pulse = 4'b0100;
    step();
    req_pulse = '0;
    cmd_ready = 1'b0;
    n = 0;
    while (!cmd_valid && n < 40) begin
      step();
      n++;
    end
    chk("reoffer_gap", n, 17);
    chk("reoffer_id", cmd_id, 2);
    chk("reoffer_drop", drop_count, 1);
    cmd_ready = 1'b1;
    step();
    wait_idle(40);

    // Enable low during offer
    cmd_ready = 1'b0;
    req_pulse = 4'b0011;
    step();
    req_pulse = '0;
    step();
    chk("en_offer_id", cmd_id, 0);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_pulse = 4'b0010;
      step();
      chk("en_hold", {cmd_valid, cmd_id}, {1'b1, 2'd0});
    end
    req_pulse = '0;
    cmd_ready = 1'b1;
    step();
    enable = 1'b1;
    cmd_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (cmd_valid) seen = 1'b1;
    end
    chk("en_cleared", seen, 0);

    // Reset during cooldown
    cmd_ready = 1'b1;
    req_pulse = 4'b1000;
    step();
    req_pulse = '0;
    step();
    chk("pre_rst_id", cmd_id, 3);
    step();
    step();
    step();
    reset = 1'b1;
    step();
    chk("cool_rst_valid", cmd_valid, 0);
    chk("cool_rst_busy", busy, 0);
    chk("cool_rst_id", cmd_id, 0);
    chk("cool_rst_drop", drop_count, 0);
    reset = 1'b0;
    req_pulse = 4'b1010;
    step();
    req_pulse = '0;
    step();
    chk("post_rst_valid", cmd_valid, 1);
    chk("post_rst_id", cmd_id, 1);
    wait_idle(40);
    step();
    wait_idle(60);

    // Randomized soak against the model
    for (int c = 0; c < 2000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      enable = ($urandom_range(0, 9) != 0);
      cmd_ready = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < N; i++)
        req_pulse[i] = ($urandom_range(0, 7) == 0);
      step();
    end
    reset = 1'b0;
    req_pulse = '0;
    enable = 1'b1;
    cmd_ready = 1'b1;
    for (int c = 0; c < 120; c++) step();
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_busy", busy, 0);

    // Drop counter saturation with a 2-bit counter
    s_en = 1'b1;
    s_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      s_pulse = 4'b0001;
      step();
      s_pulse = '0;
      chk("sat_drop", s_drop, (k - 1 > 3) ? 3 : k - 1);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk("sat_hold", s_drop, 3);
    end
    chk("sat_offer", {s_valid, s_id}, {1'b1, 2'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
